// File: rtl/stream_sched.sv
// Programmable read/write strobe scheduler: independent periods, optional beat
// limits, start/stop/hold control and an exclusive mode that never fires both ports at once.
module stream_sched #(
  parameter int CNT_W   = 8,
  parameter int BEATS_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [CNT_W-1:0]   cfg_rd_period,
  input  logic [CNT_W-1:0]   cfg_wr_period,
  input  logic [BEATS_W-1:0] cfg_rd_beats,
  input  logic [BEATS_W-1:0] cfg_wr_beats,
  input  logic               cfg_exclusive,
  input  logic               start,
  input  logic               stop,
  input  logic               hold,
  output logic               read_active,
  output logic               write_active,
  output logic               busy,
  output logic               done,
  output logic               overrun,
  output logic [BEATS_W-1:0] rd_beat_cnt,
  output logic [BEATS_W-1:0] wr_beat_cnt
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t             state;
  logic [CNT_W-1:0]   rd_period, wr_period;
  logic [CNT_W-1:0]   rd_phase, wr_phase;
  logic [BEATS_W-1:0] rd_limit, wr_limit;
  logic               excl;
  logic               rd_pend, wr_pend;

  function automatic logic [CNT_W-1:0] next_phase(input logic [CNT_W-1:0] phase,
                                                  input logic [CNT_W-1:0] period);
    return (phase == period) ? '0 : phase + CNT_W'(1);
  endfunction

  // Stage 0: dues, arbitration and pend bookkeeping from the current run state
  logic sched_p0;
  logic rd_lim_p0, wr_lim_p0, rd_fin_p0, wr_fin_p0;
  logic rd_due_p0, wr_due_p0, rd_req_p0, wr_req_p0;
  logic contend_p0, rd_iss_p0, wr_iss_p0;
  logic rd_pend_nx_p0, wr_pend_nx_p0, ovr_p0, done_p0;

  assign sched_p0  = (state == RUN) && !hold;
  assign rd_lim_p0 = (rd_limit != '0);
  assign wr_lim_p0 = (wr_limit != '0);
  assign rd_fin_p0 = rd_lim_p0 && (rd_beat_cnt == rd_limit);
  assign wr_fin_p0 = wr_lim_p0 && (wr_beat_cnt == wr_limit);

  assign rd_due_p0 = sched_p0 && !rd_fin_p0 && (rd_phase == rd_period);
  assign wr_due_p0 = sched_p0 && !wr_fin_p0 && (wr_phase == wr_period);
  assign rd_req_p0 = rd_due_p0 || (sched_p0 && !rd_fin_p0 && rd_pend);
  assign wr_req_p0 = wr_due_p0 || (sched_p0 && !wr_fin_p0 && wr_pend);

  // A side that already waited (pend) wins the next collision, so sides alternate
  assign contend_p0    = excl && rd_req_p0 && wr_req_p0;
  assign rd_iss_p0     = contend_p0 ? rd_pend  : rd_req_p0;
  assign wr_iss_p0     = contend_p0 ? !rd_pend : wr_req_p0;
  assign rd_pend_nx_p0 = contend_p0 && !rd_pend;
  assign wr_pend_nx_p0 = contend_p0 && rd_pend;

  assign ovr_p0  = (rd_due_p0 && rd_pend) || (wr_due_p0 && wr_pend);
  assign done_p0 = rd_lim_p0 && wr_lim_p0 && rd_fin_p0 && wr_fin_p0;

  // Stage 1: control FSM and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      read_active  <= 1'b0;
      write_active <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      overrun      <= 1'b0;
      rd_beat_cnt  <= '0;
      wr_beat_cnt  <= '0;
      rd_phase     <= '0;
      wr_phase     <= '0;
      rd_pend      <= 1'b0;
      wr_pend      <= 1'b0;
    end else begin
      read_active  <= 1'b0;
      write_active <= 1'b0;
      done         <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            rd_period   <= cfg_rd_period;
            wr_period   <= cfg_wr_period;
            rd_limit    <= cfg_rd_beats;
            wr_limit    <= cfg_wr_beats;
            excl        <= cfg_exclusive;
            rd_phase    <= '0;
            wr_phase    <= '0;
            rd_pend     <= 1'b0;
            wr_pend     <= 1'b0;
            rd_beat_cnt <= '0;
            wr_beat_cnt <= '0;
            overrun     <= 1'b0;
            busy        <= 1'b1;
            state       <= RUN;
          end
        end
        RUN: begin
          if (stop) begin
            state   <= IDLE;
            busy    <= 1'b0;
            rd_pend <= 1'b0;
            wr_pend <= 1'b0;
          end else if (done_p0) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else if (sched_p0) begin
            read_active  <= rd_iss_p0;
            write_active <= wr_iss_p0;
            rd_beat_cnt  <= rd_beat_cnt + BEATS_W'(rd_iss_p0);
            wr_beat_cnt  <= wr_beat_cnt + BEATS_W'(wr_iss_p0);
            if (!rd_fin_p0) rd_phase <= next_phase(rd_phase, rd_period);
            if (!wr_fin_p0) wr_phase <= next_phase(wr_phase, wr_period);
            rd_pend <= rd_pend_nx_p0;
            wr_pend <= wr_pend_nx_p0;
            if (ovr_p0) overrun <= 1'b1;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_stream_sched.sv
// Scoreboard bench for stream_sched: directed runs push expected strobes,
// a negedge monitor pops and compares each strobe the DUT presents.
module tb_stream_sched;
  localparam int CNT_W   = 8;
  localparam int BEATS_W = 16;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic [CNT_W-1:0]   cfg_rd_period = '0;
  logic [CNT_W-1:0]   cfg_wr_period = '0;
  logic [BEATS_W-1:0] cfg_rd_beats  = '0;
  logic [BEATS_W-1:0] cfg_wr_beats  = '0;
  logic               cfg_exclusive = 1'b0;
  logic               start = 1'b0;
  logic               stop  = 1'b0;
  logic               hold  = 1'b0;
  logic               read_active, write_active, busy, done, overrun;
  logic [BEATS_W-1:0] rd_beat_cnt, wr_beat_cnt;

  stream_sched #(.CNT_W(CNT_W), .BEATS_W(BEATS_W)) dut (
    .clk(clk), .rst(rst),
    .cfg_rd_period(cfg_rd_period), .cfg_wr_period(cfg_wr_period),
    .cfg_rd_beats(cfg_rd_beats), .cfg_wr_beats(cfg_wr_beats),
    .cfg_exclusive(cfg_exclusive),
    .start(start), .stop(stop), .hold(hold),
    .read_active(read_active), .write_active(write_active),
    .busy(busy), .done(done), .overrun(overrun),
    .rd_beat_cnt(rd_beat_cnt), .wr_beat_cnt(wr_beat_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int   cyc;
    logic rd;
    logic wr;
    int   rc;
    int   wc;
  } exp_t;

  exp_t sb[$];
  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt = 0;
  int t0       = 0;

  function automatic void chk(string name, logic [63:0] got, logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, got, exp, cyc);
    end
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (done === 1'b1) done_cnt++;
    if (read_active === 1'b1 || write_active === 1'b1) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_strobe: cycle %0d rd=%0b wr=%0b, no strobe expected",
                 cyc, read_active, write_active);
      end else begin
        e = sb.pop_front();
        chk("strobe_cycle", 64'(cyc), 64'(e.cyc));
        chk("strobe_bits", {62'd0, read_active, write_active}, {62'd0, e.rd, e.wr});
        chk("strobe_counts", {32'd0, rd_beat_cnt, wr_beat_cnt},
            {32'd0, BEATS_W'(e.rc), BEATS_W'(e.wc)});
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_rel(int r);
    while (cyc - t0 < r) tick();
  endtask

  task automatic setup(int rp, int wp, int rb, int wb, bit ex);
    cfg_rd_period = CNT_W'(rp);
    cfg_wr_period = CNT_W'(wp);
    cfg_rd_beats  = BEATS_W'(rb);
    cfg_wr_beats  = BEATS_W'(wb);
    cfg_exclusive = ex;
    start = 1'b1;
    t0 = cyc;
  endtask

  task automatic push(int rel, bit rd, bit wr, int rc, int wc);
    exp_t e;
    e.cyc = t0 + rel; e.rd = rd; e.wr = wr; e.rc = rc; e.wc = wc;
    sb.push_back(e);
  endtask

  task automatic do_stop();
    stop = 1'b1;
    tick();
    stop = 1'b0;
  endtask

  // Periods 31/3, unlimited; exclusive selects the deferred-read variant
  task automatic test_free(bit ex);
    int rc = 0, wc = 0;
    bit rd, wr;
    setup(31, 3, 0, 0, ex);
    for (int r = 2; r <= 100; r++) begin
      rd = ex ? (r >= 34 && r % 32 == 2) : (r >= 33 && r % 32 == 1);
      wr = (r >= 5 && r % 4 == 1);
      if (rd) rc++;
      if (wr) wc++;
      if (rd || wr) push(r, rd, wr, rc, wc);
    end
    tick();
    start = 1'b0;
    wait_rel(50);
    chk(ex ? "t2_busy" : "t1_busy", 64'(busy), 64'd1);
    wait_rel(100);
    do_stop();
    chk(ex ? "t2_busy_stop" : "t1_busy_stop", 64'(busy), 64'd0);
    chk(ex ? "t2_overrun" : "t1_overrun", 64'(overrun), 64'd0);
    wait_rel(110);
    chk(ex ? "t2_rd_cnt" : "t1_rd_cnt", 64'(rd_beat_cnt), 64'd3);
    chk(ex ? "t2_wr_cnt" : "t1_wr_cnt", 64'(wr_beat_cnt), 64'd24);
    chk(ex ? "t2_sb_drain" : "t1_sb_drain", 64'(sb.size()), 64'd0);
  endtask

  task automatic test_alt_limited();
    int d0 = done_cnt;
    setup(0, 0, 4, 4, 1'b1);
    push(2, 0, 1, 0, 1); push(3, 1, 0, 1, 1);
    push(4, 0, 1, 1, 2); push(5, 1, 0, 2, 2);
    push(6, 0, 1, 2, 3); push(7, 1, 0, 3, 3);
    push(8, 0, 1, 3, 4); push(9, 1, 0, 4, 4);
    tick();
    start = 1'b0;
    wait_rel(9);
    chk("t3_busy_last", 64'(busy), 64'd1);
    chk("t3_done_early", 64'(done), 64'd0);
    wait_rel(10);
    chk("t3_done", 64'(done), 64'd1);
    chk("t3_busy_done", 64'(busy), 64'd0);
    chk("t3_overrun", 64'(overrun), 64'd1);
    wait_rel(11);
    chk("t3_done_one_cycle", 64'(done), 64'd0);
    wait_rel(13);
    chk("t3_rd_cnt", 64'(rd_beat_cnt), 64'd4);
    chk("t3_wr_cnt", 64'(wr_beat_cnt), 64'd4);
    chk("t3_done_pulses", 64'(done_cnt - d0), 64'd1);
    chk("t3_sb_drain", 64'(sb.size()), 64'd0);
  endtask

  task automatic test_one_limited();
    int rc = 0, wc = 0;
    int d0 = done_cnt;
    bit rd, wr;
    setup(1, 7, 3, 0, 1'b0);
    for (int r = 2; r <= 40; r++) begin
      rd = (r >= 3 && r <= 7 && r % 2 == 1);
      wr = (r >= 9 && r % 8 == 1);
      if (rd) rc++;
      if (wr) wc++;
      if (rd || wr) push(r, rd, wr, rc, wc);
    end
    tick();
    start = 1'b0;
    wait_rel(20);
    chk("t4_busy", 64'(busy), 64'd1);
    chk("t4_rd_cnt", 64'(rd_beat_cnt), 64'd3);
    wait_rel(40);
    do_stop();
    chk("t4_busy_stop", 64'(busy), 64'd0);
    wait_rel(45);
    chk("t4_wr_cnt", 64'(wr_beat_cnt), 64'd4);
    chk("t4_no_done", 64'(done_cnt - d0), 64'd0);
    chk("t4_sb_drain", 64'(sb.size()), 64'd0);
  endtask

  task automatic test_hold();
    setup(3, 3, 0, 0, 1'b0);
    push(5, 1, 1, 1, 1);  push(9, 1, 1, 2, 2);
    push(23, 1, 1, 3, 3); push(27, 1, 1, 4, 4); push(31, 1, 1, 5, 5);
    tick();
    start = 1'b0;
    wait_rel(10);
    hold = 1'b1;
    wait_rel(15);
    chk("t5_rd_cnt_hold", 64'(rd_beat_cnt), 64'd2);
    chk("t5_wr_cnt_hold", 64'(wr_beat_cnt), 64'd2);
    wait_rel(20);
    hold = 1'b0;
    chk("t5_busy_hold", 64'(busy), 64'd1);
    wait_rel(32);
    do_stop();
    wait_rel(36);
    chk("t5_rd_cnt_end", 64'(rd_beat_cnt), 64'd5);
    chk("t5_sb_drain", 64'(sb.size()), 64'd0);
  endtask

  task automatic test_reset_restart();
    int d0;
    setup(0, 0, 0, 0, 1'b1);
    for (int r = 2; r <= 50; r++)
      push(r, (r % 2 == 1), (r % 2 == 0), (r - 1) / 2, r / 2);
    tick();
    start = 1'b0;
    wait_rel(30);
    chk("t6_overrun_run", 64'(overrun), 64'd1);
    wait_rel(50);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t6_rst_read", 64'(read_active), 64'd0);
    chk("t6_rst_write", 64'(write_active), 64'd0);
    chk("t6_rst_busy", 64'(busy), 64'd0);
    chk("t6_rst_done", 64'(done), 64'd0);
    chk("t6_rst_overrun", 64'(overrun), 64'd0);
    chk("t6_rst_rd_cnt", 64'(rd_beat_cnt), 64'd0);
    chk("t6_rst_wr_cnt", 64'(wr_beat_cnt), 64'd0);
    chk("t6_sb_drain_rst", 64'(sb.size()), 64'd0);
    tick();
    d0 = done_cnt;
    setup(1, 1, 2, 2, 1'b0);
    stop = 1'b1;
    push(3, 1, 1, 1, 1); push(5, 1, 1, 2, 2);
    tick();
    start = 1'b0;
    stop  = 1'b0;
    chk("t6_start_beats_stop", 64'(busy), 64'd1);
    wait_rel(6);
    chk("t6_done", 64'(done), 64'd1);
    chk("t6_rd_cnt", 64'(rd_beat_cnt), 64'd2);
    chk("t6_wr_cnt", 64'(wr_beat_cnt), 64'd2);
    chk("t6_overrun_clear", 64'(overrun), 64'd0);
    wait_rel(8);
    chk("t6_done_pulses", 64'(done_cnt - d0), 64'd1);
    chk("t6_sb_drain", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) tick();
    chk("reset_read", 64'(read_active), 64'd0);
    chk("reset_write", 64'(write_active), 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    chk("reset_overrun", 64'(overrun), 64'd0);
    chk("reset_counts", {32'd0, rd_beat_cnt, wr_beat_cnt}, 64'd0);
    rst = 1'b0;
    tick();
    test_free(1'b0);
    tick();
    test_free(1'b1);
    tick();
    test_alt_limited();
    tick();
    test_one_limited();
    tick();
    test_hold();
    tick();
    test_reset_restart();
    repeat (3) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
